ysyx_22041752_mul_ctrl: RTL and testbench

Sequencing controller between the EX stage and the iterative shift-add multiplier (ysyx_22041752_mul). It accepts one RV64M multiply request per valid/ready handshake and decodes MUL/MULH/MULHSU/MULHU/MULW into the multiplier's mul_u/mul_su/mul_h controls. It holds operands and mul_valid stable for the whole iteration, sign-extends W results, and buffers the response until EX accepts it. A one-entry last-result cache returns repeated identical requests without starting the multiplier.

---
 rtl/ysyx_22041752_mul_ctrl_pkg.sv | 39 +++
 rtl/ysyx_22041752_mul_ctrl_if.sv | 33 +++
 rtl/ysyx_22041752_mul_rcache.sv | 68 ++++++
 rtl/ysyx_22041752_mul_ctrl.sv | 149 ++++++++++++++
 tb/tb_ysyx_22041752_mul_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041752_mul_ctrl_pkg.sv
// Shared types and constants for the multiply controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_22041752_mul_ctrl_pkg;

  localparam int RF_DATA_WD = 64;

  // RV64M multiply op encodings as carried on req_op
  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULH   = 2'd1;
  localparam logic [1:0] OP_MULHSU = 2'd2;
  localparam logic [1:0] OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Control bundle understood by the shift-add multiplier
  typedef struct packed {
    logic u;
    logic su;
    logic h;
  } mul_ctl_t;

  function automatic mul_ctl_t decode_op(input logic [1:0] op);
    mul_ctl_t c;
    c = '0;
    case (op)
      OP_MULH:   c.h = 1'b1;
      OP_MULHSU: begin c.su = 1'b1; c.h = 1'b1; end
      OP_MULHU:  begin c.u  = 1'b1; c.h = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_22041752_mul_ctrl_if.sv
// EX-side request/response channel of the multiply controller.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request and response.
interface ysyx_22041752_mul_ctrl_if
  import ysyx_22041752_mul_ctrl_pkg::*;
#(
  parameter int DATA_WD = RF_DATA_WD,
  parameter int OP_WD   = 2
) ();

  logic               req_valid;
  logic               req_ready;
  logic [OP_WD-1:0]   req_op;
  logic               req_word;
  logic [DATA_WD-1:0] req_src1;
  logic [DATA_WD-1:0] req_src2;
  logic               resp_valid;
  logic               resp_ready;
  logic [DATA_WD-1:0] resp_data;

  // EX stage side
  modport master (
    output req_valid, req_op, req_word, req_src1, req_src2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  // Controller side
  modport slave (
    input  req_valid, req_op, req_word, req_src1, req_src2, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/ysyx_22041752_mul_rcache.sv
// One-entry last-result cache: tag compare on lookup, store on completion.
// Latency: lookup is combinational; a write is visible the following cycle.
// Backpressure: none; write and invalidate are single-cycle strobes.
module ysyx_22041752_mul_rcache
  import ysyx_22041752_mul_ctrl_pkg::*;
#(
  parameter int DATA_WD = RF_DATA_WD,
  parameter int OP_WD   = 2
) (
  input  logic               clk,
  input  logic               inv,
  input  logic [OP_WD-1:0]   lk_op,
  input  logic               lk_word,
  input  logic [DATA_WD-1:0] lk_src1,
  input  logic [DATA_WD-1:0] lk_src2,
  output logic               hit,
  output logic [DATA_WD-1:0] hit_data,
  input  logic               wr_en,
  input  logic [OP_WD-1:0]   wr_op,
  input  logic               wr_word,
  input  logic [DATA_WD-1:0] wr_src1,
  input  logic [DATA_WD-1:0] wr_src2,
  input  logic [DATA_WD-1:0] wr_data
);

  logic               valid_q, valid_d;
  logic [OP_WD-1:0]   op_q, op_d;
  logic               word_q, word_d;
  logic [DATA_WD-1:0] src1_q, src1_d;
  logic [DATA_WD-1:0] src2_q, src2_d;
  logic [DATA_WD-1:0] data_q, data_d;

  assign hit = valid_q && (op_q == lk_op) && (word_q == lk_word) &&
               (src1_q == lk_src1) && (src2_q == lk_src2);
  assign hit_data = data_q;

  // Next entry: a completion overwrites the entry, invalidate always wins
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    word_d  = word_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d = 1'b1;
      op_d    = wr_op;
      word_d  = wr_word;
      src1_d  = wr_src1;
      src2_d  = wr_src2;
      data_d  = wr_data;
    end
    if (inv) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage; only the valid bit needs a defined value after invalidate
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    op_q    <= op_d;
    word_q  <= word_d;
    src1_q  <= src1_d;
    src2_q  <= src2_d;
    data_q  <= data_d;
  end

endmodule

// File: rtl/ysyx_22041752_mul_ctrl.sv
// Sequences one RV64M multiply through the iterative multiplier and buffers the result.
// Latency: accept->resp_valid 1 cycle on cache hit, else RUN length + 1 (2 or 67).
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready.
module ysyx_22041752_mul_ctrl
  import ysyx_22041752_mul_ctrl_pkg::*;
#(
  parameter int DATA_WD = RF_DATA_WD,
  parameter int OP_WD   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  ysyx_22041752_mul_ctrl_if.slave ex,
  output logic                  busy,
  output logic                  mul_valid,
  output logic                  mul_u,
  output logic                  mul_su,
  output logic                  mul_h,
  output logic [DATA_WD-1:0]    mul_multiplicand,
  output logic [DATA_WD-1:0]    mul_multiplier,
  input  logic [DATA_WD-1:0]    mul_product,
  input  logic                  mul_out_valid
);

  state_e             state_q, state_d;
  mul_ctl_t           ctl_q, ctl_d;
  logic [OP_WD-1:0]   op_q, op_d;
  logic               word_q, word_d;
  logic [DATA_WD-1:0] mcand_q, mcand_d;
  logic [DATA_WD-1:0] mplier_q, mplier_d;
  logic [DATA_WD-1:0] resp_data_q, resp_data_d;

  logic [OP_WD-1:0]   req_op_eff;
  logic [DATA_WD-1:0] req_src1_eff;
  logic [DATA_WD-1:0] req_src2_eff;
  logic [DATA_WD-1:0] prod_adj;
  logic               cache_hit;
  logic [DATA_WD-1:0] cache_data;
  logic               cache_we;

  // W forms are MUL on sign-extended low words; the cache is keyed on these
  // effective operands so the tag matches what the multiplier actually saw.
  assign req_op_eff   = ex.req_word ? OP_MUL : ex.req_op;
  assign req_src1_eff = ex.req_word ? {{(DATA_WD-32){ex.req_src1[31]}}, ex.req_src1[31:0]}
                                    : ex.req_src1;
  assign req_src2_eff = ex.req_word ? {{(DATA_WD-32){ex.req_src2[31]}}, ex.req_src2[31:0]}
                                    : ex.req_src2;
  assign prod_adj     = word_q ? {{(DATA_WD-32){mul_product[31]}}, mul_product[31:0]}
                               : mul_product;

  ysyx_22041752_mul_rcache #(
    .DATA_WD (DATA_WD),
    .OP_WD   (OP_WD)
  ) u_rcache (
    .clk      (clk),
    .inv      (reset),
    .lk_op    (req_op_eff),
    .lk_word  (ex.req_word),
    .lk_src1  (req_src1_eff),
    .lk_src2  (req_src2_eff),
    .hit      (cache_hit),
    .hit_data (cache_data),
    .wr_en    (cache_we),
    .wr_op    (op_q),
    .wr_word  (word_q),
    .wr_src1  (mcand_q),
    .wr_src2  (mplier_q),
    .wr_data  (prod_adj)
  );

  assign ex.req_ready     = (state_q == ST_IDLE) && !reset;
  assign ex.resp_valid    = (state_q == ST_DONE);
  assign ex.resp_data     = resp_data_q;
  assign busy             = (state_q != ST_IDLE);
  assign mul_valid        = (state_q == ST_RUN);
  assign mul_u            = ctl_q.u;
  assign mul_su           = ctl_q.su;
  assign mul_h            = ctl_q.h;
  assign mul_multiplicand = mcand_q;
  assign mul_multiplier   = mplier_q;

  // Next-state and datapath; flush is tested first in every state
  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    op_d        = op_q;
    word_d      = word_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    resp_data_d = resp_data_q;
    cache_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex.req_valid && !flush) begin
          if (cache_hit) begin
            resp_data_d = cache_data;
            state_d     = ST_DONE;
          end else begin
            ctl_d    = decode_op(req_op_eff);
            op_d     = req_op_eff;
            word_d   = ex.req_word;
            mcand_d  = req_src1_eff;
            mplier_d = req_src2_eff;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mul_out_valid) begin
          resp_data_d = prod_adj;
          cache_we    = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // Leaving DONE drops mul_valid for at least one cycle before the
        // next RUN, which is what restarts the multiplier's iteration count.
        if (flush || ex.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and held operand/result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ctl_q       <= '0;
      op_q        <= '0;
      word_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      op_q        <= op_d;
      word_q      <= word_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_mul_ctrl.sv
// Self-checking bench for the multiply controller with a behavioural multiplier.
// Latency: n/a.
// Backpressure: bench exercises response stalls and flush.
module tb_ysyx_22041752_mul_ctrl;
  import ysyx_22041752_mul_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  ysyx_22041752_mul_ctrl_if #(.DATA_WD(64), .OP_WD(2)) ex ();

  logic        busy, mul_valid, mul_u, mul_su, mul_h, mul_out_valid;
  logic [63:0] mul_multiplicand, mul_multiplier, mul_product;

  ysyx_22041752_mul_ctrl #(.DATA_WD(64), .OP_WD(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .ex               (ex),
    .busy             (busy),
    .mul_valid        (mul_valid),
    .mul_u            (mul_u),
    .mul_su           (mul_su),
    .mul_h            (mul_h),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_out_valid    (mul_out_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural multiplier: out_valid on the 66th consecutive mul_valid cycle, 1st if an operand is zero
  function automatic logic [63:0] mult_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic u, input logic su, input logic h);
    logic [127:0] ea, eb, p;
    ea = u ? {64'b0, a} : {{64{a[63]}}, a};
    eb = (u || su) ? {64'b0, b} : {{64{b[63]}}, b};
    p  = ea * eb;
    return h ? p[127:64] : p[63:0];
  endfunction

  int mcnt = 0;
  always @(posedge clk) mcnt <= mul_valid ? mcnt + 1 : 0;
  assign mul_product   = mult_model(mul_multiplicand, mul_multiplier, mul_u, mul_su, mul_h);
  assign mul_out_valid = mul_valid &&
    ((mcnt + 1) == (((mul_multiplicand == 64'd0) || (mul_multiplier == 64'd0)) ? 1 : 66));

  // Architectural result of an RV64M request
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    logic [31:0]  lo;
    if (word) begin
      lo = a[31:0] * b[31:0];
      return {{32{lo[31]}}, lo};
    end
    ea = (op == 2'd3) ? {64'b0, a} : {{64{a[63]}}, a};
    eb = (op == 2'd0 || op == 2'd1) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  // Drives one request, waits for the response, optionally stalls it, and reports observations
  task automatic do_req(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input int stall,
                        output int lat, output logic [63:0] data, output bit timeout,
                        output bit saw_mv, output bit ctl_bad, output bit stall_bad,
                        output logic [2:0] ctl_seen);
    int guard;
    bit first;
    logic [63:0] m1, m2;
    timeout = 0; saw_mv = 0; ctl_bad = 0; stall_bad = 0; ctl_seen = '0;
    lat = 0; data = '0; first = 1; m1 = '0; m2 = '0;
    @(negedge clk);
    ex.req_valid = 1'b1; ex.req_op = op; ex.req_word = word;
    ex.req_src1 = a; ex.req_src2 = b;
    guard = 0;
    while (!ex.req_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!ex.req_ready) begin timeout = 1; ex.req_valid = 1'b0; return; end
    @(negedge clk);
    ex.req_valid = 1'b0;
    lat = 1;
    while (!ex.resp_valid && lat < 300) begin
      if (mul_valid) begin
        saw_mv = 1;
        if (first) begin
          ctl_seen = {mul_u, mul_su, mul_h}; m1 = mul_multiplicand; m2 = mul_multiplier; first = 0;
        end else if ({mul_u, mul_su, mul_h} !== ctl_seen || mul_multiplicand !== m1 ||
                     mul_multiplier !== m2) begin
          ctl_bad = 1;
        end
      end
      @(negedge clk);
      lat++;
    end
    if (!ex.resp_valid) begin timeout = 1; return; end
    data = ex.resp_data;
    if (mul_valid) saw_mv = 1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!ex.resp_valid || ex.resp_data !== data || ex.req_ready !== 1'b0 || mul_valid) stall_bad = 1;
    end
    ex.resp_ready = 1'b1;
    @(negedge clk);
    ex.resp_ready = 1'b0;
  endtask

  int lat;
  logic [63:0] data;
  bit to, smv, cbad, sbad;
  logic [2:0] cseen;

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    ex.req_valid = 1'b0; ex.req_op = '0; ex.req_word = 1'b0;
    ex.req_src1 = '0; ex.req_src2 = '0; ex.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ex.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", ex.req_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (ex.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", ex.resp_valid); end
    n_checks++; if (ex.resp_data !== 64'd0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", ex.resp_data); end
    n_checks++; if (mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mul_valid: got %b want 0", mul_valid); end
    n_checks++; if ({mul_multiplicand, mul_multiplier} !== 128'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h want 0", mul_multiplicand, mul_multiplier); end
    n_checks++; if (ex.req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %b want 1", ex.req_ready); end
  endtask

  task automatic test_mulhu();
    do_req(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (to) begin n_fail++; $display("FAIL mulhu_timeout: no response"); end
    n_checks++; if (data !== 64'd1) begin n_fail++; $display("FAIL mulhu_data: got %h want 1", data); end
    n_checks++; if (lat !== 67) begin n_fail++; $display("FAIL mulhu_latency: got %0d want 67", lat); end
    n_checks++; if (cseen !== 3'b101) begin n_fail++; $display("FAIL mulhu_ctl u/su/h: got %b want 101", cseen); end
    n_checks++; if (cbad) begin n_fail++; $display("FAIL mulhu_ctl_stable: controls/operands moved during RUN"); end
  endtask

  task automatic test_results();
    do_req(2'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (data !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 67) begin n_fail++; $display("FAIL mulw: got %h lat %0d want fffffffffffffffe lat 67", data, lat); end
    do_req(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (data !== 64'hFFFF_FFFF_FFFF_FFFF || cseen !== 3'b011) begin n_fail++; $display("FAIL mulhsu: got %h ctl %b want ffffffffffffffff ctl 011", data, cseen); end
    do_req(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (data !== 64'hFFFF_FFFF_FFFF_FFFF || cseen !== 3'b001) begin n_fail++; $display("FAIL mulh: got %h ctl %b want ffffffffffffffff ctl 001", data, cseen); end
  endtask

  task automatic test_cache_hit();
    do_req(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", lat); end
    n_checks++; if (smv) begin n_fail++; $display("FAIL hit_mul_valid: got 1 want 0"); end
    n_checks++; if (data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL hit_data: got %h want ffffffffffffffff", data); end
    do_req(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (lat !== 67 || data !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL op_miss: got %h lat %0d want fffffffffffffff1 lat 67", data, lat); end
  endtask

  task automatic test_flush();
    bit seen;
    int guard;
    @(negedge clk);
    ex.req_valid = 1'b1; ex.req_op = 2'd0; ex.req_word = 1'b0; ex.req_src1 = 64'd7; ex.req_src2 = 64'd9;
    @(negedge clk);
    ex.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (mul_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_run: mul_valid got %b want 1", mul_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (mul_valid !== 1'b0 || ex.resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_abort: mv %b rv %b busy %b want 0 0 0", mul_valid, ex.resp_valid, busy); end
    seen = 0;
    repeat (80) begin @(negedge clk); if (ex.resp_valid) seen = 1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL flush_no_resp: resp_valid seen after flush"); end
    do_req(2'd0, 1'b0, 64'd7, 64'd9, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (data !== 64'd63 || lat !== 67) begin n_fail++; $display("FAIL flush_reissue: got %0d lat %0d want 63 lat 67", data, lat); end
    // request coinciding with flush is dropped
    @(negedge clk);
    ex.req_valid = 1'b1; ex.req_src1 = 64'd3; ex.req_src2 = 64'd4; flush = 1'b1;
    @(negedge clk);
    ex.req_valid = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0 || ex.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_req: busy %b rv %b want 0 0", busy, ex.resp_valid); end
    // flush together with resp_ready in DONE
    @(negedge clk);
    ex.req_valid = 1'b1; ex.req_src1 = 64'd0; ex.req_src2 = 64'd5;
    @(negedge clk);
    ex.req_valid = 1'b0;
    guard = 0;
    while (!ex.resp_valid && guard < 200) begin @(negedge clk); guard++; end
    n_checks++; if (ex.resp_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done_wait: resp_valid got %b want 1", ex.resp_valid); end
    flush = 1'b1; ex.resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; ex.resp_ready = 1'b0;
    n_checks++; if (ex.resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_done: rv %b busy %b want 0 0", ex.resp_valid, busy); end
  endtask

  task automatic test_zero_stall();
    do_req(2'd0, 1'b0, 64'd0, 64'h1234, 5, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (data !== 64'd0 || lat !== 2) begin n_fail++; $display("FAIL zero_op: got %h lat %0d want 0 lat 2", data, lat); end
    n_checks++; if (sbad) begin n_fail++; $display("FAIL stall_stable: resp/req_ready changed while stalled"); end
  endtask

  task automatic test_reset_mid_run();
    do_req(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (lat !== 67) begin n_fail++; $display("FAIL rst_prime: lat %0d want 67", lat); end
    @(negedge clk);
    ex.req_valid = 1'b1; ex.req_op = 2'd0; ex.req_word = 1'b0; ex.req_src1 = 64'd5; ex.req_src2 = 64'd6;
    @(negedge clk);
    ex.req_valid = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (ex.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req_ready: got %b want 0", ex.req_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || mul_valid !== 1'b0 || ex.resp_valid !== 1'b0 || mul_multiplicand !== 64'd0) begin n_fail++; $display("FAIL rst_mid_state: busy %b mv %b rv %b mc %h want 0", busy, mul_valid, ex.resp_valid, mul_multiplicand); end
    do_req(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, lat, data, to, smv, cbad, sbad, cseen);
    n_checks++; if (lat !== 67 || data !== 64'd1) begin n_fail++; $display("FAIL rst_cache_inv: got %h lat %0d want 1 lat 67", data, lat); end
  endtask

  task automatic test_random();
    logic [1:0]   op, k_op;
    logic         word, k_word, k_vld;
    logic [63:0]  a, b, k_a, k_b, exp_d, ea, eb;
    bit           hit, have_prev;
    int           exp_lat, sel, stall;
    k_vld = 0; have_prev = 0; k_op = '0; k_word = 0; k_a = '0; k_b = '0;
    op = '0; word = 0; a = '0; b = '0;
    for (int i = 0; i < 40; i++) begin
      if (!(have_prev && $urandom_range(0, 3) == 0)) begin
        op = 2'($urandom_range(0, 3));
        word = ($urandom_range(0, 3) == 0);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        sel = $urandom_range(0, 7);
        if (sel == 0) a = '0;
        else if (sel == 1) b = '0;
        else if (sel == 2) a = {32'd0, $urandom};
      end
      have_prev = 1;
      hit = k_vld && (k_op == (word ? 2'd0 : op)) && (k_word == word) && (k_a == a) && (k_b == b);
      ea = word ? {{32{a[31]}}, a[31:0]} : a;
      eb = word ? {{32{b[31]}}, b[31:0]} : b;
      exp_lat = hit ? 1 : ((ea == 0 || eb == 0) ? 2 : 67);
      exp_d = ref_result(word ? 2'd0 : op, word, a, b);
      stall = $urandom_range(0, 3);
      do_req(op, word, a, b, stall, lat, data, to, smv, cbad, sbad, cseen);
      n_checks++; if (to || data !== exp_d) begin n_fail++; $display("FAIL rand_data[%0d]: op %0d w %b got %h want %h", i, op, word, data, exp_d); end
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
      n_checks++; if (smv !== !hit || cbad || sbad) begin n_fail++; $display("FAIL rand_ctl[%0d]: mv %b want %b ctl_bad %b stall_bad %b", i, smv, !hit, cbad, sbad); end
      k_vld = 1; k_op = word ? 2'd0 : op; k_word = word; k_a = a; k_b = b;
    end
  endtask

  initial begin
    test_reset();
    test_mulhu();
    test_results();
    test_cache_hit();
    test_flush();
    test_zero_stall();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
